// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Purpose  : Packs a length-prefixed byte stream into little-endian 32-bit
//            words and writes them to instruction memory from word 0 upward.
// Revision : 1.0  initial release
// ============================================================================
module imem_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic                  in_valid_i,
    input  logic [7:0]            in_data_i,
    output logic                  in_ready_o,
    output logic                  we_o,
    output logic [ADDR_WIDTH-3:0] waddr_o,
    output logic [31:0]           wdata_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o
);
    localparam int          c_WW  = ADDR_WIDTH - 2;
    localparam logic [16:0] c_CAP = 17'(1) << c_WW;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LEN_LO = 2'd1,
        S_LEN_HI = 2'd2,
        S_DATA   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       count_q, count_d;
    logic [1:0]        lane_q, lane_d;
    logic [c_WW-1:0]   widx_q, widx_d;
    logic [23:0]       word_q, word_d;
    logic              we_q, we_d;
    logic [c_WW-1:0]   waddr_q, waddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    logic              w_hs;
    logic [15:0]       w_len;
    logic              w_last;

    assign in_ready_o = (state_q != S_IDLE);
    assign w_hs       = in_valid_i & in_ready_o;
    assign w_len      = {in_data_i, count_q[7:0]};
    // Length check guarantees count_q >= 1 and the index never exceeds capacity-1.
    assign w_last     = ({{(16-c_WW){1'b0}}, widx_q} == (count_q - 16'd1));

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            count_q <= '0;
            lane_q  <= '0;
            widx_q  <= '0;
            word_q  <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            lane_q  <= lane_d;
            widx_q  <= widx_d;
            word_q  <= word_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        lane_d  = lane_q;
        widx_d  = widx_q;
        word_d  = word_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        error_d = error_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_LEN_LO;
                    error_d = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            S_LEN_LO: begin
                if (w_hs) begin
                    count_d[7:0] = in_data_i;
                    state_d      = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (w_hs) begin
                    count_d[15:8] = in_data_i;
                    if ((w_len == 16'd0) || ({1'b0, w_len} > c_CAP)) begin
                        error_d = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        widx_d  = '0;
                        lane_d  = '0;
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_hs) begin
                    case (lane_q)
                        2'd0: word_d[7:0]   = in_data_i;
                        2'd1: word_d[15:8]  = in_data_i;
                        2'd2: word_d[23:16] = in_data_i;
                        default: begin
                            we_d    = 1'b1;
                            waddr_d = widx_q;
                            wdata_d = {in_data_i, word_q};
                            widx_d  = widx_q + 1'b1;
                            if (w_last) begin
                                state_d = S_IDLE;
                                done_d  = 1'b1;
                                busy_d  = 1'b0;
                            end
                        end
                    endcase
                    lane_d = lane_q + 2'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign we_o    = we_q;
    assign waddr_o = waddr_q;
    assign wdata_o = wdata_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign error_o = error_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_loader
// Purpose  : Directed and randomized self-checking bench for imem_loader.
// Revision : 1.0  initial release
// ============================================================================
module tb_imem_loader;
    localparam int c_AW = 8;
    localparam int c_WW = c_AW - 2;

    logic              clk_i = 1'b0;
    logic              reset_i;
    logic              start_i;
    logic              in_valid_i;
    logic [7:0]        in_data_i;
    logic              in_ready_o;
    logic              we_o;
    logic [c_WW-1:0]   waddr_o;
    logic [31:0]       wdata_o;
    logic              busy_o;
    logic              done_o;
    logic              error_o;

    imem_loader #(.ADDR_WIDTH(c_AW)) dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .start_i    (start_i),
        .in_valid_i (in_valid_i),
        .in_data_i  (in_data_i),
        .in_ready_o (in_ready_o),
        .we_o       (we_o),
        .waddr_o    (waddr_o),
        .wdata_o    (wdata_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .error_o    (error_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Observed writes and completion pulses.
    logic [c_WW-1:0] got_addr[$];
    logic [31:0]     got_data[$];
    int              done_cnt     = 0;
    int              done_alone   = 0;

    always @(negedge clk_i) begin
        if (we_o) begin
            got_addr.push_back(waddr_o);
            got_data.push_back(wdata_o);
        end
        if (done_o) begin
            done_cnt++;
            if (!we_o) done_alone++;
        end
    end

    // Stimulus stream and the reference expectations derived from it.
    logic [7:0]  stim[$];
    logic [31:0] exp_data[$];
    int          exp_done;
    logic        exp_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: length from the first two bytes, then every complete group of
    // four following bytes is one little-endian word, up to the length.
    function automatic void model(input int n_sent);
        int len, ndata, nwords;
        exp_data.delete();
        len = int'(stim[0]) + 256 * int'(stim[1]);
        exp_err  = (len == 0) || (len > (1 << c_WW));
        exp_done = 0;
        if (exp_err) return;
        ndata  = n_sent - 2;
        nwords = ndata / 4;
        if (nwords > len) nwords = len;
        for (int w = 0; w < nwords; w++)
            exp_data.push_back({stim[2+4*w+3], stim[2+4*w+2], stim[2+4*w+1], stim[2+4*w]});
        exp_done = (ndata >= 4 * len) ? 1 : 0;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    // Sends stim[0..n-1]; optional random gaps; start held high while byte pulse_at is offered.
    task automatic send(input int n, input int maxgap, input int pulse_at);
        for (int i = 0; i < n; i++) begin
            int  budget;
            logic hs;
            repeat ($urandom_range(0, maxgap)) tick();
            in_valid_i = 1'b1;
            in_data_i  = stim[i];
            start_i    = (i == pulse_at);
            budget     = 0;
            do begin
                hs = in_ready_o;
                tick();
                budget++;
            end while (!hs && budget < 20);
            if (!hs) chk("handshake_timeout", 64'(0), 64'(1));
            in_valid_i = 1'b0;
            start_i    = 1'b0;
        end
    endtask

    task automatic clear_obs();
        got_addr.delete();
        got_data.delete();
        done_cnt   = 0;
        done_alone = 0;
    endtask

    task automatic compare_writes(input string tag);
        chk({tag, "_nwrites"}, 64'(got_data.size()), 64'(exp_data.size()));
        for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
            chk({tag, "_waddr"}, 64'(got_addr[i]), 64'(i));
            chk({tag, "_wdata"}, 64'(got_data[i]), 64'(exp_data[i]));
        end
        chk({tag, "_done"}, 64'(done_cnt), 64'(exp_done));
        chk({tag, "_done_with_we"}, 64'(done_alone), 64'(0));
        chk({tag, "_busy"}, 64'(busy_o), 64'(0));
        chk({tag, "_error"}, 64'(error_o), 64'(exp_err));
    endtask

    task automatic build_prog();
        stim.delete();
        stim = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
    endtask

    initial begin
        reset_i    = 1'b1;
        start_i    = 1'b0;
        in_valid_i = 1'b1;
        in_data_i  = 8'hA5;

        // 1: reset, then idle with in_valid held high.
        repeat (3) tick();
        reset_i = 1'b0;
        clear_obs();
        repeat (4) tick();
        chk("rst_in_ready", 64'(in_ready_o), 64'(0));
        chk("rst_we",       64'(we_o),       64'(0));
        chk("rst_busy",     64'(busy_o),     64'(0));
        chk("rst_done",     64'(done_o),     64'(0));
        chk("rst_error",    64'(error_o),    64'(0));
        chk("rst_waddr",    64'(waddr_o),    64'(0));
        chk("rst_wdata",    64'(wdata_o),    64'(0));
        chk("rst_nwrites",  64'(got_data.size()), 64'(0));
        in_valid_i = 1'b0;

        // 2: back-to-back two-word program.
        build_prog();
        clear_obs();
        pulse_start();
        chk("t2_busy_after_start", 64'(busy_o), 64'(1));
        send(stim.size(), 0, -1);
        repeat (4) tick();
        model(stim.size());
        compare_writes("t2");
        if (got_data.size() == 2) begin
            chk("t2_word0_const", 64'(got_data[0]), 64'h00100513);
            chk("t2_word1_const", 64'(got_data[1]), 64'h00200593);
        end

        // 3: same stream with random bubbles.
        clear_obs();
        pulse_start();
        send(stim.size(), 3, -1);
        repeat (4) tick();
        model(stim.size());
        compare_writes("t3");

        // 4: bad lengths, then a valid start clears the sticky error.
        stim = '{8'h00, 8'h00};
        clear_obs();
        pulse_start();
        send(2, 0, -1);
        repeat (3) tick();
        model(2);
        compare_writes("t4_zero");
        stim = '{8'h41, 8'h00};
        clear_obs();
        pulse_start();
        send(2, 1, -1);
        repeat (3) tick();
        model(2);
        compare_writes("t4_over");
        build_prog();
        clear_obs();
        pulse_start();
        chk("t4_error_cleared", 64'(error_o), 64'(0));
        send(stim.size(), 1, -1);
        repeat (4) tick();
        model(stim.size());
        compare_writes("t4_recover");

        // 5: reset in the middle of a three-word load.
        stim.delete();
        stim.push_back(8'h03);
        stim.push_back(8'h00);
        for (int i = 0; i < 12; i++) stim.push_back(8'($urandom));
        clear_obs();
        pulse_start();
        send(8, 1, -1);
        reset_i = 1'b1;
        tick();
        tick();
        reset_i = 1'b0;
        chk("t5_busy_after_reset", 64'(busy_o), 64'(0));
        repeat (4) tick();
        model(8);
        chk("t5_nwrites", 64'(got_data.size()), 64'(exp_data.size()));
        if (got_data.size() >= 1) begin
            chk("t5_waddr0", 64'(got_addr[0]), 64'(0));
            chk("t5_wdata0", 64'(got_data[0]), 64'(exp_data[0]));
        end
        chk("t5_done", 64'(done_cnt), 64'(0));
        clear_obs();
        pulse_start();
        send(stim.size(), 2, -1);
        repeat (4) tick();
        model(stim.size());
        compare_writes("t5_fresh");

        // 6: full capacity with a start pulse while busy.
        stim.delete();
        stim.push_back(8'h40);
        stim.push_back(8'h00);
        for (int i = 0; i < 256; i++) stim.push_back(8'($urandom));
        clear_obs();
        pulse_start();
        send(stim.size(), 1, 100);
        repeat (4) tick();
        model(stim.size());
        compare_writes("t6");
        if (got_addr.size() > 0)
            chk("t6_last_waddr", 64'(got_addr[got_addr.size()-1]), 64'(63));
        chk("t6_still_idle", 64'(in_ready_o), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
